// File: rtl/cpu_trace_serializer_pkg.sv
// Shared constants, state encoding and helpers for the CPU trace serializer
// and the benches that drive the downstream format checker.
package cpu_trace_pkg;

    // ASCII characters used by the two trace line formats.
    localparam logic [7:0] ASC_CARET  = 8'h5e;  // ^
    localparam logic [7:0] ASC_AT     = 8'h40;  // @
    localparam logic [7:0] ASC_COLON  = 8'h3a;  // :
    localparam logic [7:0] ASC_DOLLAR = 8'h24;  // $
    localparam logic [7:0] ASC_STAR   = 8'h2a;  // *
    localparam logic [7:0] ASC_LT     = 8'h3c;  // <
    localparam logic [7:0] ASC_EQ     = 8'h3d;  // =
    localparam logic [7:0] ASC_HASH   = 8'h23;  // #
    localparam logic [7:0] ASC_SPACE  = 8'h20;
    localparam logic [7:0] ASC_ZERO   = 8'h30;  // '0'
    localparam logic [7:0] ASC_A_LC   = 8'h61;  // 'a'

    // Format codes reported by the downstream checker.
    localparam logic [1:0] FMT_REG = 2'b01;
    localparam logic [1:0] FMT_MEM = 2'b10;

    // Serializer state encoding. CARET..HASH are contiguous so that
    // char_valid reduces to a range compare.
    typedef logic [4:0] state_t;
    localparam state_t ST_IDLE  = 5'd0;
    localparam state_t ST_ERR   = 5'd1;
    localparam state_t ST_CARET = 5'd2;
    localparam state_t ST_TIME  = 5'd3;
    localparam state_t ST_AT    = 5'd4;
    localparam state_t ST_PC    = 5'd5;
    localparam state_t ST_COLON = 5'd6;
    localparam state_t ST_SP1   = 5'd7;
    localparam state_t ST_KIND  = 5'd8;
    localparam state_t ST_REG   = 5'd9;
    localparam state_t ST_ADDR  = 5'd10;
    localparam state_t ST_SP2   = 5'd11;
    localparam state_t ST_LT    = 5'd12;
    localparam state_t ST_EQ    = 5'd13;
    localparam state_t ST_SP3   = 5'd14;
    localparam state_t ST_DATA  = 5'd15;
    localparam state_t ST_HASH  = 5'd16;
    localparam state_t ST_GAP   = 5'd17;

    // Nibble to lowercase hex ASCII. Also serves decimal digits 0..9.
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        if (n < 4'd10)
            return ASC_ZERO + {4'h0, n};
        else
            return ASC_A_LC + {4'h0, n} - 8'd10;
    endfunction

    // A BCD field is acceptable to the checker when its length is 1..4
    // and every used digit is 1..9 (the checker rejects '0' here).
    function automatic logic bcd_field_ok(input logic [15:0] digits,
                                          input logic [2:0]  len);
        logic       ok;
        logic [3:0] d;
        ok = (len >= 3'd1) && (len <= 3'd4);
        for (int i = 0; i < 4; i++) begin
            d = digits[i*4 +: 4];
            if ((i < int'(len)) && ((d == 4'd0) || (d > 4'd9)))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/cpu_trace_serializer_if.sv
// Request channel of the trace serializer: one trace record per
// valid/ready handshake.
interface cpu_trace_serializer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_kind;     // 0 = register record, 1 = memory record
    logic [15:0] time_digits;  // BCD, low time_len nibbles used
    logic [2:0]  time_len;
    logic [31:0] pc;
    logic [15:0] reg_digits;   // BCD, low reg_len nibbles used
    logic [2:0]  reg_len;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (
        output req_valid, req_kind, time_digits, time_len, pc,
               reg_digits, reg_len, addr, data,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_kind, time_digits, time_len, pc,
               reg_digits, reg_len, addr, data,
        output req_ready
    );
endinterface

// File: rtl/cpu_trace_serializer_charmux.sv
// Character generator: picks the digit/nibble addressed by the field index
// for the given state and turns it into an ASCII byte.
module cpu_trace_charmux
    import cpu_trace_pkg::*;
#(
    parameter logic [7:0] IDLE_CHAR = 8'h20
) (
    input  state_t      state,
    input  logic [2:0]  idx,
    input  logic        kind,
    input  logic [15:0] time_digits,
    input  logic [15:0] reg_digits,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic [7:0]  ch
);

    // Map state + index to the character shown for that cycle.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        ch = IDLE_CHAR;
        case (state)
            ST_CARET: ch = ASC_CARET;
            ST_TIME:  ch = nib2hex(time_digits[{idx[1:0], 2'b00} +: 4]);
            ST_AT:    ch = ASC_AT;
            ST_PC:    ch = nib2hex(pc[{idx, 2'b00} +: 4]);
            ST_COLON: ch = ASC_COLON;
            ST_SP1:   ch = ASC_SPACE;
            ST_KIND:  ch = kind ? ASC_STAR : ASC_DOLLAR;
            ST_REG:   ch = nib2hex(reg_digits[{idx[1:0], 2'b00} +: 4]);
            ST_ADDR:  ch = nib2hex(addr[{idx, 2'b00} +: 4]);
            ST_SP2:   ch = ASC_SPACE;
            ST_LT:    ch = ASC_LT;
            ST_EQ:    ch = ASC_EQ;
            ST_SP3:   ch = ASC_SPACE;
            ST_DATA:  ch = nib2hex(data[{idx, 2'b00} +: 4]);
            ST_HASH:  ch = ASC_HASH;
            default:  ch = IDLE_CHAR;   // IDLE, ERR, GAP
        endcase
    end

endmodule

// File: rtl/cpu_trace_serializer.sv
// Serializes one CPU write-back/store trace record per handshake into the
// ASCII stream consumed by the output-format checker, one char per clock.
module cpu_trace_serializer
    import cpu_trace_pkg::*;
#(
    parameter logic [7:0] IDLE_CHAR  = 8'h20,
    parameter int         GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_trace_serializer_if.slave  req,
    output logic [7:0]             char,
    output logic                   char_valid,
    output logic                   err
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gap_q, gap_d;
    logic [7:0]  char_d;
    logic        accept;
    logic        legal;

    // Captured request fields.
    logic        kind_q;
    logic [15:0] time_digits_q;
    logic [2:0]  time_len_q;
    logic [31:0] pc_q;
    logic [15:0] reg_digits_q;
    logic [2:0]  reg_len_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;

    assign req.req_ready = (state_q == ST_IDLE) && !reset;
    assign accept        = req.req_valid && req.req_ready;

    // Register fields are only checked for register records.
    assign legal = bcd_field_ok(req.time_digits, req.time_len) &&
                   (req.req_kind || bcd_field_ok(req.reg_digits, req.reg_len));

    // Next state and field/gap counters.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = legal ? ST_CARET : ST_ERR;
            ST_ERR:   state_d = ST_IDLE;
            ST_CARET: begin
                state_d = ST_TIME;
                idx_d   = time_len_q - 3'd1;
            end
            ST_TIME: begin
                if (idx_q == 3'd0) state_d = ST_AT;
                else               idx_d   = idx_q - 3'd1;
            end
            ST_AT: begin
                state_d = ST_PC;
                idx_d   = 3'd7;
            end
            ST_PC: begin
                if (idx_q == 3'd0) state_d = ST_COLON;
                else               idx_d   = idx_q - 3'd1;
            end
            ST_COLON: state_d = ST_SP1;
            ST_SP1:   state_d = ST_KIND;
            ST_KIND: begin
                state_d = kind_q ? ST_ADDR : ST_REG;
                idx_d   = kind_q ? 3'd7 : (reg_len_q - 3'd1);
            end
            ST_REG, ST_ADDR: begin
                if (idx_q == 3'd0) state_d = ST_SP2;
                else               idx_d   = idx_q - 3'd1;
            end
            ST_SP2:   state_d = ST_LT;
            ST_LT:    state_d = ST_EQ;
            ST_EQ:    state_d = ST_SP3;
            ST_SP3: begin
                state_d = ST_DATA;
                idx_d   = 3'd7;
            end
            ST_DATA: begin
                if (idx_q == 3'd0) state_d = ST_HASH;
                else               idx_d   = idx_q - 3'd1;
            end
            ST_HASH: begin
                state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                gap_d   = 4'd0;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = 4'd0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // The output byte is registered, so it is computed from the next state.
    cpu_trace_charmux #(.IDLE_CHAR(IDLE_CHAR)) u_charmux (
        .state       (state_d),
        .idx         (idx_d),
        .kind        (kind_q),
        .time_digits (time_digits_q),
        .reg_digits  (reg_digits_q),
        .pc          (pc_q),
        .addr        (addr_q),
        .data        (data_q),
        .ch          (char_d)
    );

    // Capture the request on the handshake.
    // NOTE: pure data holding registers carry no reset; they are always written before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            kind_q        <= req.req_kind;
            time_digits_q <= req.time_digits;
            time_len_q    <= req.time_len;
            pc_q          <= req.pc;
            reg_digits_q  <= req.reg_digits;
            reg_len_q     <= req.reg_len;
            addr_q        <= req.addr;
            data_q        <= req.data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            gap_q      <= 4'd0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            char       <= char_d;
            char_valid <= (state_d >= ST_CARET) && (state_d <= ST_HASH);
            err        <= (state_d == ST_ERR);
        end
    end

endmodule
